// File: rtl/sobel_rd_stage_if.sv
// Pixel-stream bundle between display timing / image ROM and the Sobel read stage.
// The master side drives timing, threshold and ROM data; the slave side returns the ROM address and edge pixel.
`timescale 1ns/1ps
interface sobel_rd_stage_if #(
    parameter int ADDR_W = 16
);
    logic              area;
    logic              v_sync;
    logic [7:0]        thresh;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        dout;

    modport master (
        output area, v_sync, thresh, rom_data,
        input  rom_addr, dout
    );

    modport slave (
        input  area, v_sync, thresh, rom_data,
        output rom_addr, dout
    );
endinterface

// File: rtl/sobel_rd_stage.sv
// Streams a grayscale image out of ROM in raster order and emits a thresholded
// Sobel edge map (RGB332 white/black), 4 cycles behind each consumed pixel.
`timescale 1ns/1ps
module sobel_rd_stage #(
    parameter int IMG_W  = 198,
    parameter int IMG_H  = 198,
    parameter int ADDR_W = 16
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    sobel_rd_stage_if.slave  bus
);
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NPIX = IMG_W * IMG_H;

    logic [ADDR_W-1:0] addr_reg;
    logic [CW-1:0]     col_reg, col1_reg;
    logic [RW-1:0]     row_reg, row1_reg;
    logic              vs_d_reg, v1_reg, w_ok_reg, w3_reg;
    logic [7:0]        lb0_q_reg, lb1_q_reg;
    logic signed [10:0] gx_reg, gy_reg;
    logic [7:0]        dout_reg;
    logic              resync;

    assign resync = bus.v_sync & ~vs_d_reg;

    // Fetch counters; a frame-sync edge takes priority over an active pixel.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_reg <= 1'b0;
            addr_reg <= '0;
            col_reg  <= '0;
            row_reg  <= '0;
            col1_reg <= '0;
            row1_reg <= '0;
            v1_reg   <= 1'b0;
        end else begin
            vs_d_reg <= bus.v_sync;
            if (resync) begin
                addr_reg <= '0;
                col_reg  <= '0;
                row_reg  <= '0;
                v1_reg   <= 1'b0;
            end else begin
                v1_reg <= bus.area;
                if (bus.area) begin
                    col1_reg <= col_reg;
                    row1_reg <= row_reg;
                    addr_reg <= (addr_reg == ADDR_W'(NPIX - 1)) ? '0 : addr_reg + 1'b1;
                    if (col_reg == CW'(IMG_W - 1)) begin
                        col_reg <= '0;
                        row_reg <= (row_reg == RW'(IMG_H - 1)) ? '0 : row_reg + 1'b1;
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
            end
        end
    end

    // Line buffers: read is issued alongside the ROM fetch so both arrive in the v1 cycle;
    // the write trails by one pixel, so the read never targets the column being written.
    logic [7:0] lb0_mem [IMG_W];
    logic [7:0] lb1_mem [IMG_W];

    always_ff @(posedge vga_clk) begin
        if (bus.area) begin
            lb0_q_reg <= lb0_mem[col_reg];
            lb1_q_reg <= lb1_mem[col_reg];
        end
        if (v1_reg) begin
            lb0_mem[col1_reg] <= bus.rom_data;
            lb1_mem[col1_reg] <= lb0_q_reg;
        end
    end

    // 3x3 window, row 0 oldest, column 2 newest.
    logic [7:0] new_col [3];
    assign new_col[0] = lb1_q_reg;
    assign new_col[1] = lb0_q_reg;
    assign new_col[2] = bus.rom_data;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [7:0] c0_reg, c1_reg, c2_reg;
            always_ff @(posedge vga_clk or negedge rst_n) begin
                if (!rst_n) begin
                    c0_reg <= '0;
                    c1_reg <= '0;
                    c2_reg <= '0;
                end else if (v1_reg) begin
                    c0_reg <= c1_reg;
                    c1_reg <= c2_reg;
                    c2_reg <= new_col[gi];
                end
            end
        end
    endgenerate

    logic [7:0] p00, p01, p02, p10, p12, p20, p21, p22;
    assign p00 = g_row[0].c0_reg;
    assign p01 = g_row[0].c1_reg;
    assign p02 = g_row[0].c2_reg;
    assign p10 = g_row[1].c0_reg;
    assign p12 = g_row[1].c2_reg;
    assign p20 = g_row[2].c0_reg;
    assign p21 = g_row[2].c1_reg;
    assign p22 = g_row[2].c2_reg;

    logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
    always_comb begin
        gx_pos = 11'(p02) + 11'({p12, 1'b0}) + 11'(p22);
        gx_neg = 11'(p00) + 11'({p10, 1'b0}) + 11'(p20);
        gy_pos = 11'(p20) + 11'({p21, 1'b0}) + 11'(p22);
        gy_neg = 11'(p00) + 11'({p01, 1'b0}) + 11'(p02);
    end

    logic [10:0] ax, ay;
    logic [11:0] sum_abs;
    logic [7:0]  mag;
    always_comb begin
        ax      = gx_reg[10] ? $unsigned(-gx_reg) : $unsigned(gx_reg);
        ay      = gy_reg[10] ? $unsigned(-gy_reg) : $unsigned(gy_reg);
        sum_abs = {1'b0, ax} + {1'b0, ay};
        mag     = (sum_abs > 12'd255) ? 8'hFF : sum_abs[7:0];
    end

    // Valid flags run every cycle so blanking gaps travel down as bubbles.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ok_reg <= 1'b0;
            w3_reg   <= 1'b0;
            gx_reg   <= '0;
            gy_reg   <= '0;
            dout_reg <= 8'h00;
        end else begin
            gx_reg <= $signed(gx_pos - gx_neg);
            gy_reg <= $signed(gy_pos - gy_neg);
            if (resync) begin
                w_ok_reg <= 1'b0;
                w3_reg   <= 1'b0;
                dout_reg <= 8'h00;
            end else begin
                w_ok_reg <= v1_reg && (row1_reg >= RW'(2)) && (col1_reg >= CW'(2));
                w3_reg   <= w_ok_reg;
                dout_reg <= (w3_reg && (mag > bus.thresh)) ? 8'hFF : 8'h00;
            end
        end
    end

    assign bus.rom_addr = addr_reg;
    assign bus.dout     = dout_reg;

endmodule
